// File: rtl/layer_output_serializer_if.sv
// layer_output_serializer_if: frame start/data in, serialized word stream out.
// slave: i_start, din in; o_start, o_valid, o_last, dout, o_busy, o_err out.
interface layer_output_serializer_if #(
  parameter int DATA_WIDTH  = 24,
  parameter int NUM_NEURONS = 10
);
  logic                              i_start;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] din;
  logic                              o_start;
  logic                              o_valid;
  logic                              o_last;
  logic signed [DATA_WIDTH-1:0]      dout;
  logic                              o_busy;
  logic                              o_err;

  modport master (
    output i_start, din,
    input  o_start, o_valid, o_last,
    input  dout, o_busy, o_err
  );

  modport slave (
    input  i_start, din,
    output o_start, o_valid, o_last,
    output dout, o_busy, o_err
  );
endinterface

// File: rtl/layer_output_serializer.sv
// layer_output_serializer: times the cell bank MAC latency, captures all
// results, applies activation and streams them one word per cycle.
// Ports: clk, rst (sync, active-high), bus (slave modport):
//   i_start/din in; o_start/o_valid/o_last/dout out; o_busy, o_err status.
// Macro ACT_RELU_EN: captured words are clamped at zero when negative.
module layer_output_serializer #(
  parameter int DATA_WIDTH    = 24,
  parameter int NUM_NEURONS   = 10,
  parameter int INPUT_LENGTH  = 784,
  parameter int CAPTURE_DELAY = INPUT_LENGTH + 2
) (
  input logic                      clk,
  input logic                      rst,
  layer_output_serializer_if.slave bus
);
  localparam int TW = $clog2(CAPTURE_DELAY + 1);
  localparam int IW = $clog2(NUM_NEURONS + 1);

  typedef enum logic {T_IDLE, T_COUNT} tstate_t;
  typedef enum logic {E_IDLE, E_EMIT} estate_t;

  tstate_t t_q, t_d;
  estate_t e_q, e_d;

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;

  logic [DATA_WIDTH-1:0] wbuf_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0] wbuf_d [NUM_NEURONS];

  logic capture;
  logic last_el;
  logic accept;
  logic drop;
  logic start_err;

  assign capture = (t_q == T_COUNT) &&
                   (tcnt_q == TW'(CAPTURE_DELAY));
  assign last_el = (e_q == E_EMIT) &&
                   (idx_q == IW'(NUM_NEURONS - 1));
  // the slot of the last element is free for a new frame
  assign accept    = capture && ((e_q == E_IDLE) || last_el);
  assign drop      = capture && !accept;
  assign start_err = bus.i_start && (t_q == T_COUNT);

  always_comb begin
    t_d    = t_q;
    tcnt_d = tcnt_q;
    unique case (t_q)
      T_IDLE: begin
        if (bus.i_start) begin
          t_d    = T_COUNT;
          tcnt_d = TW'(1);
        end
      end
      T_COUNT: begin
        if (capture) begin
          t_d    = T_IDLE;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: t_d = T_IDLE;
    endcase
  end

  always_comb begin
    e_d   = e_q;
    idx_d = idx_q;
    err_d = start_err | drop;
    unique case (e_q)
      E_IDLE: begin
        if (accept) begin
          e_d   = E_EMIT;
          idx_d = '0;
        end
      end
      E_EMIT: begin
        if (last_el) begin
          idx_d = '0;
          e_d   = accept ? E_EMIT : E_IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: e_d = E_IDLE;
    endcase
  end

  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      wbuf_d[n] = wbuf_q[n];
      if (accept) begin
`ifdef ACT_RELU_EN
        wbuf_d[n] =
          bus.din[n*DATA_WIDTH + DATA_WIDTH - 1] ?
          '0 : bus.din[n*DATA_WIDTH +: DATA_WIDTH];
`else
        wbuf_d[n] = bus.din[n*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q    <= T_IDLE;
      e_q    <= E_IDLE;
      tcnt_q <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++)
        wbuf_q[n] <= '0;
    end else begin
      t_q    <= t_d;
      e_q    <= e_d;
      tcnt_q <= tcnt_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
      for (int n = 0; n < NUM_NEURONS; n++)
        wbuf_q[n] <= wbuf_d[n];
    end
  end

  assign bus.o_valid = (e_q == E_EMIT);
  assign bus.o_start = bus.o_valid && (idx_q == '0);
  assign bus.o_last  = last_el;
  assign bus.o_busy  = (t_q != T_IDLE) || (e_q != E_IDLE);
  assign bus.o_err   = err_q;

  always_comb begin
    bus.dout = '0;
    for (int n = 0; n < NUM_NEURONS; n++)
      if (bus.o_valid && (idx_q == IW'(n)))
        bus.dout = wbuf_q[n];
  end
endmodule

// File: tb/tb_layer_output_serializer.sv
// tb_layer_output_serializer: two instances (capture delay 10 and 2)
// on shared random stimulus, scored against a timeline model.
module tb_layer_output_serializer;
  localparam int DW = 24;
  localparam int NN = 4;

  typedef struct {
    int          inst;
    int          cyc;
    logic [DW-1:0] w;
    bit          first;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st  = 1'b0;
  logic [NN*DW-1:0] dinv = '0;

  always #5 clk = ~clk;

  layer_output_serializer_if #(.DATA_WIDTH(DW), .NUM_NEURONS(NN)) if0 ();
  layer_output_serializer_if #(.DATA_WIDTH(DW), .NUM_NEURONS(NN)) if1 ();

  assign if0.i_start = st;
  assign if0.din     = dinv;
  assign if1.i_start = st;
  assign if1.din     = dinv;

  layer_output_serializer #(
    .DATA_WIDTH(DW), .NUM_NEURONS(NN),
    .INPUT_LENGTH(8), .CAPTURE_DELAY(10)
  ) u0 (.clk(clk), .rst(rst), .bus(if0.slave));

  layer_output_serializer #(
    .DATA_WIDTH(DW), .NUM_NEURONS(NN),
    .INPUT_LENGTH(0), .CAPTURE_DELAY(2)
  ) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic          ov [2];
  logic          os [2];
  logic          ol [2];
  logic          ob [2];
  logic          oe [2];
  logic [DW-1:0] od [2];

  assign ov[0] = if0.o_valid;
  assign os[0] = if0.o_start;
  assign ol[0] = if0.o_last;
  assign ob[0] = if0.o_busy;
  assign oe[0] = if0.o_err;
  assign od[0] = if0.dout;
  assign ov[1] = if1.o_valid;
  assign os[1] = if1.o_start;
  assign ol[1] = if1.o_last;
  assign ob[1] = if1.o_busy;
  assign oe[1] = if1.o_err;
  assign od[1] = if1.dout;

  int   vec  = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   chk_en = 1'b0;
  exp_t sq[$];

  int dly [2] = '{10, 2};
  int m_ts [2];
  int m_el [2];
  bit m_ep [2];
  bit exp_busy [2];
  bit exp_err [2];

  function automatic logic [DW-1:0] act(logic [DW-1:0] w);
`ifdef ACT_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic check(string nm, int i,
                       logic [31:0] a, logic [31:0] e);
    vec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h",
               nm, i, cyc, a, e);
    end
  endtask

  task automatic model(bit r, bit s, logic [NN*DW-1:0] d);
    for (int i = 0; i < 2; i++) begin
      bit a;
      bit c;
      exp_busy[i] = ((m_ts[i] >= 0) && (cyc <= m_ts[i] + dly[i])) ||
                    (m_el[i] >= cyc);
      exp_err[i] = m_ep[i];
      m_ep[i] = 1'b0;
      if (r) begin
        m_ts[i] = -1;
        m_el[i] = -1;
      end else begin
        a = (m_ts[i] >= 0) && (cyc > m_ts[i]) &&
            (cyc <= m_ts[i] + dly[i]);
        c = a && (cyc == m_ts[i] + dly[i]);
        if (s) begin
          if (a) m_ep[i] = 1'b1;
          else m_ts[i] = cyc;
        end
        if (c) begin
          if (m_el[i] > cyc) begin
            m_ep[i] = 1'b1;
          end else begin
            for (int n = 0; n < NN; n++) begin
              exp_t e;
              e.inst  = i;
              e.cyc   = cyc + 1 + n;
              e.w     = act(d[n*DW +: DW]);
              e.first = (n == 0);
              e.last  = (n == NN - 1);
              sq.push_back(e);
            end
            m_el[i] = cyc + NN;
          end
        end
      end
    end
    if (r) begin
      for (int j = sq.size() - 1; j >= 0; j--)
        if (sq[j].cyc > cyc) sq.delete(j);
    end
  endtask

  task automatic step(bit r, bit s, logic [NN*DW-1:0] d);
    @(posedge clk);
    #1;
    cyc++;
    rst  = r;
    st   = s;
    dinv = d;
    model(r, s, d);
  endtask

  function automatic logic [NN*DW-1:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int j;
        j = -1;
        for (int k = 0; k < sq.size(); k++)
          if (j < 0 && sq[k].inst == i) j = k;
        check("busy", i, 32'(ob[i]), 32'(exp_busy[i]));
        check("err", i, 32'(oe[i]), 32'(exp_err[i]));
        if (j >= 0 && sq[j].cyc < cyc) begin
          check("missed_word", i, 32'(sq[j].cyc), 32'(cyc));
          sq.delete(j);
        end else if (j >= 0 && sq[j].cyc == cyc) begin
          check("valid", i, 32'(ov[i]), 32'd1);
          check("dout", i, 32'(od[i]), 32'(sq[j].w));
          check("start", i, 32'(os[i]), 32'(sq[j].first));
          check("last", i, 32'(ol[i]), 32'(sq[j].last));
          sq.delete(j);
        end else begin
          check("valid_idle", i, 32'(ov[i]), 32'd0);
          check("dout_idle", i, 32'(od[i]), 32'd0);
          check("start_idle", i, 32'(os[i]), 32'd0);
          check("last_idle", i, 32'(ol[i]), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [NN*DW-1:0] pat;
    pat = {24'd7, 24'd0, 24'd3, 24'hFFFFFB};
    for (int i = 0; i < 2; i++) begin
      m_ts[i] = -1;
      m_el[i] = -1;
      m_ep[i] = 1'b0;
      exp_busy[i] = 1'b0;
      exp_err[i] = 1'b0;
    end
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, '0);
    // start t0, ignored start t4, capture t10, back-to-back t11/t21
    for (int t = 0; t < 30; t++)
      step(1'b0, (t == 0) || (t == 4) || (t == 11),
           ((t == 10) || (t == 21)) ? pat : rnd());
    // reset mid-frame, then a fresh frame
    for (int t = 0; t < 26; t++)
      step(t == 6, (t == 0) || (t == 8),
           (t == 18) ? pat : rnd());
    for (int t = 0; t < 3000; t++)
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 5) == 0), rnd());
    for (int t = 0; t < 30; t++)
      step(1'b0, 1'b0, rnd());
    @(posedge clk);
    #1;
    check("queue_drained", 0, 32'(sq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, nerr);
    $finish;
  end
endmodule
